array_16_rd_front: RTL and testbench

Read front end for the 64-entry x 1024-bit `array_16_ext` data array, sitting directly upstream of it and producing its consumer-facing response stream. Converts a ready/valid read-request stream into array read enables and absorbs the array's fixed one-cycle read latency with a small in-order response buffer, so downstream backpressure never drops or corrupts read data. Also forwards the single write stream to the array write port.

---
 rtl/array_16_rd_front.sv | 110 +++++++++++
 tb/tb_array_16_rd_front.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_16_rd_front.sv
// Read front end for the array_16_ext data array: ready/valid reads with a
// small in-order response buffer that absorbs the one-cycle array latency.
module array_16_rd_front #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [DATA_W-1:0] sram_wdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    logic              inflight_q, inflight_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_q [DEPTH];

    logic [CW:0] occ;
    logic        fire;
    logic        empty;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credit counts reads already issued, so resp_ready never reaches req_ready.
    assign occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign req_ready = reset_n && (occ < DEPTH_OCC);
    assign fire      = req_valid && req_ready;

    assign sram_ren   = fire;
    assign sram_raddr = req_addr;
    assign sram_wen   = wr_valid && reset_n;
    assign sram_waddr = wr_addr;
    assign sram_wdata = wr_data;

    assign empty      = (count_q == '0);
    assign resp_valid = !empty || inflight_q;
    assign resp_data  = empty ? sram_rdata : buf_q[rd_ptr_q];
    assign pop        = !empty && resp_ready;
    assign push       = inflight_q && !(empty && resp_ready);

    always_comb begin
        inflight_d = fire;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_q[wr_ptr_q] <= sram_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(push && (count_q == DEPTH_CNT)));
        end
    end

endmodule

// File: tb/tb_array_16_rd_front.sv
// Bench for array_16_rd_front: write-first array model, reference memory
// and an in-order response scoreboard.
module tb_array_16_rd_front;

    localparam int AW = 6;
    localparam int DW = 1024;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          sram_ren;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;
    logic          sram_wen;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] arr_mem [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] sbq [$];

    array_16_rd_front #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sram_ren   (sram_ren),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .sram_wen   (sram_wen),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        logic [31:0] w;
        w = 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
        return {(DW / 32){w}};
    endfunction

    // Array model: one-cycle read latency, write-first, garbage when idle.
    initial begin
        for (int i = 0; i < 64; i++) arr_mem[i] <= init_word(i);
    end

    always @(posedge clock) begin
        if (sram_wen) arr_mem[sram_waddr] <= sram_wdata;
        if (sram_ren)
            sram_rdata <= (sram_wen && sram_waddr == sram_raddr) ?
                          sram_wdata : arr_mem[sram_raddr];
        else
            sram_rdata <= rnd_data();
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: flush on reset, pop/compare on handshake, push on request fire.
    always @(negedge clock) begin
        logic [DW-1:0] exp;
        if (!reset_n) begin
            sbq.delete();
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_sram_ren", 64'(sram_ren), 64'd0);
            chk("rst_sram_wen", 64'(sram_wen), 64'd0);
        end else begin
            if (resp_valid && resp_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected act=%h t=%0t",
                             resp_data[63:0], $time);
                end else begin
                    exp = sbq.pop_front();
                    if (resp_data !== exp) begin
                        errors++;
                        $display("FAIL resp_data act[63:0]=%h exp[63:0]=%h t=%0t",
                                 resp_data[63:0], exp[63:0], $time);
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp = (wr_valid && wr_addr == req_addr) ? wr_data : ref_mem[req_addr];
                sbq.push_back(exp);
                if (sbq.size() > DEPTH + 1) begin
                    checks++;
                    errors++;
                    $display("FAIL credit_overrun act=%0d exp<=%0d", sbq.size(), DEPTH + 1);
                end
                chk("sram_raddr", 64'(sram_raddr), 64'(req_addr));
            end
            if (wr_valid) ref_mem[wr_addr] = wr_data;
            chk("sram_ren", 64'(sram_ren), 64'(req_valid && req_ready));
            chk("sram_wen", 64'(sram_wen), 64'(wr_valid));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [DW-1:0] xd, yd;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        reset_n    = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 6'd3;
        resp_ready = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 6'd7;
        wr_data    = rnd_data();
        repeat (3) step();
        reset_n   = 1'b1;
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        @(negedge clock);
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        chk("rel_resp_valid", 64'(resp_valid), 64'd0);
        chk("rel_wr_dropped", arr_mem[7][63:0], init_word(7) >> 0);

        // Write then bypass read of addr 5
        step();
        wr_valid = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = {(DW / 8){8'hA5}};
        step();
        wr_valid  = 1'b0;
        req_valid = 1'b1;
        req_addr  = 6'd5;
        @(negedge clock);
        chk("t1_fire", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        chk("t1_valid", 64'(resp_valid), 64'd1);
        chk("t1_data", resp_data[63:0], {8{8'hA5}});
        step();
        @(negedge clock);
        chk("t1_idle", 64'(resp_valid), 64'd0);

        // Back-to-back reads 0..7
        for (int i = 0; i < 9; i++) begin
            step();
            req_valid = (i < 8);
            req_addr  = 6'(i);
            @(negedge clock);
            if (i < 8) chk("t2_req_ready", 64'(req_ready), 64'd1);
            if (i >= 1) chk("t2_resp_valid", 64'(resp_valid), 64'd1);
        end
        step();
        @(negedge clock);
        chk("t2_idle", 64'(resp_valid), 64'd0);

        // Backpressure: two credits, third stalls until a pop
        step();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 6'd1;
        @(negedge clock);
        chk("t3_fire1", 64'(req_ready), 64'd1);
        step();
        req_addr = 6'd2;
        @(negedge clock);
        chk("t3_fire2", 64'(req_ready), 64'd1);
        step();
        req_addr = 6'd3;
        @(negedge clock);
        chk("t3_stall", 64'(req_ready), 64'd0);
        chk("t3_head", resp_data[63:0], ref_mem[1][63:0]);
        step();
        @(negedge clock);
        chk("t3_stall2", 64'(req_ready), 64'd0);
        step();
        resp_ready = 1'b1;
        @(negedge clock);
        chk("t3_no_ready_path", 64'(req_ready), 64'd0);
        step();
        @(negedge clock);
        chk("t3_resume", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        repeat (3) step();

        // Same-cycle write and read of addr 9
        yd = rnd_data();
        xd = rnd_data();
        wr_valid = 1'b1;
        wr_addr  = 6'd9;
        wr_data  = yd;
        step();
        wr_data   = xd;
        req_valid = 1'b1;
        req_addr  = 6'd9;
        @(negedge clock);
        chk("t4_fire", 64'(req_ready), 64'd1);
        step();
        wr_valid  = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        chk("t4_valid", 64'(resp_valid), 64'd1);
        chk("t4_data", resp_data[63:0], xd[63:0]);

        // Reset with two buffered responses
        step();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 6'd5;
        step();
        req_addr = 6'd9;
        step();
        req_valid = 1'b0;
        step();
        @(negedge clock);
        chk("t5_buffered", 64'(resp_valid), 64'd1);
        step();
        reset_n = 1'b0;
        step();
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 6'd9;
        @(negedge clock);
        chk("t5_resp_valid", 64'(resp_valid), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        chk("t5_valid", 64'(resp_valid), 64'd1);
        chk("t5_data", resp_data[63:0], xd[63:0]);

        // Random traffic on a narrow address range to provoke hazards
        for (int n = 0; n < 10000; n++) begin
            step();
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = 6'($urandom_range(0, 15));
            wr_valid   = ($urandom_range(0, 3) == 0);
            wr_addr    = 6'($urandom_range(0, 15));
            wr_data    = rnd_data();
            resp_ready = ($urandom_range(0, 9) < 6);
        end
        step();
        req_valid  = 1'b0;
        wr_valid   = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 20 && sbq.size() != 0; n++) step();
        step();
        @(negedge clock);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        chk("drain_idle", 64'(resp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
